// File: rtl/input_buffer_mc.sv
// ---------------------------------------------------------------------------
// input_buffer_mc
// Circular vector queue at the front of the trace chains. Each entry stores
// {eof, chainId, vector}. Entries sit in a dual-port RAM with a registered
// read, then pass through a one-entry in-flight stage into a first-word
// fall-through output register that drains over a valid/ready handshake.
// 'count' includes RAM entries, the in-flight read and the output register.
// The almost-full threshold can be set at runtime over the config bus while
// tracing is idle.
//
// Optional feature macro: IB_OVERFLOW_CNT_EN
//   When defined, the block has an extra 16-bit saturating overflow_cnt port
//   that counts pushes rejected because the queue was full.
// ---------------------------------------------------------------------------
module input_buffer_mc #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IB_DEPTH   = 8,
  parameter int NUM_CHAINS = 2,
  parameter int CONFIG_ID  = 1,
  localparam int CHAIN_W   = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enqueue,
  input  logic                             eof_in,
  input  logic [CHAIN_W-1:0]               chainId_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]     vector_in,
  input  logic                             tracing,
  input  logic [7:0]                       configId,
  input  logic [7:0]                       configData,
  input  logic                             ready_in,
  output logic                             valid_out,
  output logic                             eof_out,
  output logic [CHAIN_W-1:0]               chainId_out,
  output logic [N-1:0][DATA_WIDTH-1:0]     vector_out,
  output logic                             full,
  output logic                             almost_full,
  output logic                             empty
`ifdef IB_OVERFLOW_CNT_EN
  ,
  output logic [15:0]                      overflow_cnt
`endif
);

  localparam int PTR_W   = $clog2(IB_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + CHAIN_W + N * DATA_WIDTH;

  localparam logic [7:0]       CFG_ID     = 8'(CONFIG_ID);
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(IB_DEPTH);
  localparam logic [CNT_W-1:0] THRESH_RST = CNT_W'(IB_DEPTH - 1);

  // Storage and pointers
  logic [ENTRY_W-1:0] mem [IB_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Occupancy and threshold
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic [CNT_W-1:0]   af_thresh;
  logic [CNT_W-1:0]   af_thresh_next;
  logic [CNT_W-1:0]   cfg_val;
  logic [CNT_W-1:0]   in_pipe;

  // In-flight read stage between the RAM and the output register
  logic               rd_valid;
  logic [ENTRY_W-1:0] rd_data;

  // Handshake / control
  logic               push_ok;
  logic               pop;
  logic               move;
  logic               read_issue;
  logic               cfg_hit;

  // Only the low bits of configData form the threshold field.
  generate
    if (PTR_W + 1 < 8) begin : g_cfg_unused
      logic unused_cfg_bits;
      assign unused_cfg_bits = ^configData[7:PTR_W+1];
    end
  endgenerate

  assign cfg_val = configData[PTR_W:0];
  assign cfg_hit = !tracing && (configId == CFG_ID);

  // A push lands only while tracing and when the registered count has room;
  // a pop is a plain valid/ready handshake on the output register.
  assign push_ok = enqueue && tracing && !full;
  assign pop     = valid_out && ready_in;

  // The in-flight entry advances whenever the output register is free or
  // being emptied this cycle.
  assign move = rd_valid && (!valid_out || pop);

  // Entries already committed to the read pipeline (output reg + in-flight);
  // anything in count beyond that is still unread in the RAM.
  assign in_pipe = CNT_W'(valid_out) + CNT_W'(rd_valid);

  // Fetch the next unread entry when the in-flight slot is (or becomes) free,
  // which keeps one entry per cycle flowing under sustained push and pop.
  assign read_issue = (count > in_pipe) && (!rd_valid || move);

  // Next occupancy from this cycle's accepted push and pop
  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Runtime almost-full threshold, clamped to 1..IB_DEPTH
  always_comb begin
    af_thresh_next = af_thresh;
    if (cfg_hit) begin
      if (cfg_val == '0) begin
        af_thresh_next = CNT_W'(1);
      end else if (cfg_val > DEPTH_CNT) begin
        af_thresh_next = DEPTH_CNT;
      end else begin
        af_thresh_next = cfg_val;
      end
    end
  end

  // RAM write port and registered read port; no reset needed on storage
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {eof_in, chainId_in, vector_in};
    end
    if (read_issue) begin
      rd_data <= mem[rd_ptr];
    end
  end

  // Pointers, occupancy, status flags and in-flight valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      af_thresh   <= THRESH_RST;
      rd_valid    <= 1'b0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (read_issue) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (read_issue) begin
        rd_valid <= 1'b1;
      end else if (move) begin
        rd_valid <= 1'b0;
      end
      count       <= count_next;
      af_thresh   <= af_thresh_next;
      full        <= (count_next == DEPTH_CNT);
      empty       <= (count_next == '0);
      almost_full <= (count_next >= af_thresh_next);
    end
  end

  // First-word fall-through output register; holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out   <= 1'b0;
      eof_out     <= 1'b0;
      chainId_out <= '0;
      vector_out  <= '0;
    end else begin
      if (move) begin
        valid_out                            <= 1'b1;
        {eof_out, chainId_out, vector_out}   <= rd_data;
      end else if (pop) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef IB_OVERFLOW_CNT_EN
  localparam logic [7:0] CLR_ID = 8'(CONFIG_ID + 1);

  // Saturating count of pushes refused because the queue was full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_cnt <= '0;
    end else if (!tracing && (configId == CLR_ID)) begin
      overflow_cnt <= '0;
    end else if (enqueue && tracing && full && (overflow_cnt != 16'hFFFF)) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end
`endif

endmodule
